// File: rtl/keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : keypad_scan_fifo
// Purpose  : Row-strobed key matrix scanner with per-key debounce and a
//            press/release event FIFO with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_scan_fifo #(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int REL_EVT    = 0,
  localparam int NK        = ROWS * COLS,
  localparam int KW        = $clog2(NK)
) (
  input  logic            clk,
  input  logic            RST,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [KW-1:0]   ev_code,
  output logic            ev_release,
  output logic [NK-1:0]   key_state,
  output logic            any_key,
  output logic            overflow,
  input  logic            clr_ovf
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [ROWS-1:0] w_row_strobe;
  logic            w_sample_now;
  logic            w_commit_last;

  logic [DW-1:0]   r_div;
  logic [RW-1:0]   r_row_idx;
  logic [CW-1:0]   r_col_idx;
  logic [COLS-1:0] r_col_lat;

  logic [NK-1:0]   r_key_state;
  logic [3:0]      r_cnt [NK];
  logic [KW-1:0]   w_key;
  logic            w_smp_pressed;
  logic            w_differs;
  logic [3:0]      w_cnt_inc;
  logic            w_toggle;
  logic            w_push;
  logic            w_push_rel;

  logic [KW:0]     r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            r_overflow;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_drop;

  // Scan FSM next state and row strobe decode; rows float high outside DRIVE
  always_comb begin
    w_state_nxt   = r_state;
    w_row_strobe  = '1;
    w_sample_now  = 1'b0;
    w_commit_last = 1'b0;
    case (r_state)
      S_IDLE: w_state_nxt = S_DRIVE;
      S_DRIVE: begin
        w_row_strobe[r_row_idx] = 1'b0;
        if (r_div == DW'(SCAN_DIV - 1)) begin
          w_sample_now = 1'b1;
          w_state_nxt  = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (r_col_idx == CW'(COLS - 1)) begin
          w_commit_last = 1'b1;
          w_state_nxt   = S_DRIVE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Scan state, row dwell counter, column latch and row/column indices
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_div     <= '0;
      r_row_idx <= '0;
      r_col_idx <= '0;
      r_col_lat <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_DRIVE) begin
        r_div <= w_sample_now ? '0 : r_div + 1'b1;
      end
      if (w_sample_now) begin
        r_col_lat <= col;
        r_col_idx <= '0;
      end else if (r_state == S_COMMIT) begin
        r_col_idx <= r_col_idx + 1'b1;
      end
      if (w_commit_last) begin
        r_row_idx <= (r_row_idx == RW'(ROWS - 1)) ? '0 : r_row_idx + 1'b1;
      end
    end
  end

  // One key is evaluated per COMMIT cycle, so events arrive in column order
  assign w_key         = KW'(int'(r_row_idx) * COLS + int'(r_col_idx));
  assign w_smp_pressed = ~r_col_lat[r_col_idx];
  assign w_differs     = w_smp_pressed != r_key_state[w_key];
  assign w_cnt_inc     = r_cnt[w_key] + 4'd1;
  assign w_toggle      = (r_state == S_COMMIT) && w_differs && (w_cnt_inc == 4'(DEB_SCANS));
  assign w_push_rel    = r_key_state[w_key];
  assign w_push        = w_toggle && (!w_push_rel || (REL_EVT != 0));

  // Debounce: count disagreeing frames, flip the level once the run is long enough
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      r_key_state <= '0;
      for (int i = 0; i < NK; i++) begin
        r_cnt[i] <= '0;
      end
    end else if (r_state == S_COMMIT) begin
      if (!w_differs) begin
        r_cnt[w_key] <= '0;
      end else if (w_toggle) begin
        r_cnt[w_key]       <= '0;
        r_key_state[w_key] <= ~r_key_state[w_key];
      end else begin
        r_cnt[w_key] <= w_cnt_inc;
      end
    end
  end

  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands
  assign w_full  = r_count == (AW + 1)'(FIFO_DEPTH);
  assign w_pop   = ev_valid && ev_ready;
  assign w_wr_en = w_push && (!w_full || w_pop);
  assign w_drop  = w_push && w_full && !w_pop;

  // Event FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= {w_push_rel, w_key};
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (clr_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign row        = w_row_strobe;
  assign ev_valid   = r_count != '0;
  assign ev_code    = r_mem[r_rd_ptr][KW-1:0];
  assign ev_release = r_mem[r_rd_ptr][KW];
  assign key_state  = r_key_state;
  assign any_key    = |r_key_state;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_keypad_scan_fifo
// Purpose  : Self-checking bench for keypad_scan_fifo (4x4 matrix, short
//            row dwell). Two instances: A = depth 4 with release events,
//            B = depth 8 press-only. Both see the same emulated keypad.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_fifo;

  localparam int FRAME = 48;  // 4 rows x (8 drive + 4 commit) cycles

  logic        clk = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  col;
  logic [15:0] pressed = '0;
  logic        rdy_a = 1'b0, rdy_b = 1'b1, clr_a = 1'b0, clr_b = 1'b0;

  logic [3:0]  row_a, row_b, code_a, code_b;
  logic        val_a, val_b, rel_a, rel_b, any_a, any_b, ovf_a, ovf_b;
  logic [15:0] ks_a, ks_b;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int       n = 0;          // cycles since reset release (current cycle)
  bit [15:0] m_ks;
  int       m_cnt [16];
  bit [3:0] m_lat;
  bit       m_ovf_a, m_ovf_b;
  int       qa[$], qb[$];
  int       log_a[$], log_b[$];

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_SCANS(3),
                     .FIFO_DEPTH(4), .REL_EVT(1)) dut_a (
    .clk(clk), .RST(RST), .col(col), .row(row_a),
    .ev_valid(val_a), .ev_ready(rdy_a), .ev_code(code_a), .ev_release(rel_a),
    .key_state(ks_a), .any_key(any_a), .overflow(ovf_a), .clr_ovf(clr_a)
  );

  keypad_scan_fifo #(.ROWS(4), .COLS(4), .SCAN_DIV(8), .DEB_SCANS(3),
                     .FIFO_DEPTH(8), .REL_EVT(0)) dut_b (
    .clk(clk), .RST(RST), .col(col), .row(row_b),
    .ev_valid(val_b), .ev_ready(rdy_b), .ev_code(code_b), .ev_release(rel_b),
    .key_state(ks_b), .any_key(any_b), .overflow(ovf_b), .clr_ovf(clr_b)
  );

  always #5 clk = ~clk;

  // Keypad emulation: a closed key pulls its column low while its row is strobed
  always_comb begin
    col = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_a[r] && pressed[r*4+c]) col[c] = 1'b0;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, then advance the model one cycle
  always @(negedge clk) begin
    int m, rr, ph, c, k, ev;
    bit popa, popb, pusha, pushb, dropa, dropb;
    logic [3:0] erow;
    if (RST) begin
      n = 0; m_ks = '0; m_lat = '0; m_ovf_a = 0; m_ovf_b = 0;
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      qa.delete(); qb.delete();
      chk("rst_row", row_a, 4'hF);
      chk("rst_valid", val_a, 0);
      chk("rst_code", code_a, 0);
      chk("rst_release", rel_a, 0);
      chk("rst_key_state", ks_a, 0);
      chk("rst_any_key", any_a, 0);
      chk("rst_overflow", ovf_a, 0);
      chk("rst_valid_b", val_b, 0);
    end else begin
      m = 0; rr = 0; ph = 0;
      erow = 4'hF;
      if (n >= 1) begin
        m  = n - 1;
        rr = (m / 12) % 4;
        ph = m % 12;
        if (ph < 8) erow = ~(4'b0001 << rr);
      end
      chk("row", row_a, erow);
      chk("row_b", row_b, erow);
      chk("valid_a", val_a, qa.size() > 0);
      chk("valid_b", val_b, qb.size() > 0);
      if (qa.size() > 0) chk("head_a", {rel_a, code_a}, qa[0]);
      if (qb.size() > 0) chk("head_b", {rel_b, code_b}, qb[0]);
      chk("key_state", ks_a, m_ks);
      chk("key_state_b", ks_b, m_ks);
      chk("any_key", any_a, m_ks != 0);
      chk("any_key_b", any_b, m_ks != 0);
      chk("overflow_a", ovf_a, m_ovf_a);
      chk("overflow_b", ovf_b, m_ovf_b);

      if (val_a && rdy_a) log_a.push_back({rel_a, code_a});
      if (val_b && rdy_b) log_b.push_back({rel_b, code_b});

      pusha = 0; pushb = 0; ev = 0;
      if (n >= 1 && ph == 7)
        for (int j = 0; j < 4; j++) m_lat[j] = pressed[rr*4+j];
      if (n >= 1 && ph >= 8) begin
        c = ph - 8;
        k = rr * 4 + c;
        if (m_lat[c] != m_ks[k]) begin
          m_cnt[k]++;
          if (m_cnt[k] == 3) begin
            m_cnt[k] = 0;
            m_ks[k]  = ~m_ks[k];
            ev    = m_ks[k] ? k : k + 16;
            pusha = 1;
            pushb = m_ks[k];
          end
        end else begin
          m_cnt[k] = 0;
        end
      end

      popa = qa.size() > 0 && rdy_a;
      popb = qb.size() > 0 && rdy_b;
      if (popa) void'(qa.pop_front());
      if (popb) void'(qb.pop_front());
      dropa = 0; dropb = 0;
      if (pusha) begin
        if (qa.size() >= 4) dropa = 1; else qa.push_back(ev);
      end
      if (pushb) begin
        if (qb.size() >= 8) dropb = 1; else qb.push_back(ev);
      end
      if (dropa) m_ovf_a = 1; else if (clr_a) m_ovf_a = 0;
      if (dropb) m_ovf_b = 1; else if (clr_b) m_ovf_b = 0;
      n++;
    end
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    pressed = '0; rdy_a = 0; rdy_b = 1; clr_a = 0;
    RST = 1'b1;
    cyc(3);
    RST = 1'b0;
  endtask

  // Step to the first cycle of a frame (row 0, first drive cycle)
  task automatic align();
    do cyc(1); while (n % FRAME != 1);
  endtask

  task automatic pop_a(input string nm, input int exp_code, input int exp_rel);
    chk($sformatf("%s_valid", nm), val_a, 1);
    chk($sformatf("%s_code", nm), code_a, exp_code);
    chk($sformatf("%s_release", nm), rel_a, exp_rel);
    rdy_a = 1'b1;
    cyc(1);
    rdy_a = 1'b0;
  endtask

  initial begin
    // Reset state and scan start
    cyc(3);
    chk("rst_row_lit", row_a, 4'hF);
    chk("rst_valid_lit", val_a, 0);
    RST = 1'b0;
    cyc(1);
    chk("first_drive_row0", row_a, 4'hE);

    // Key (2,1) held for five frames, then released
    rdy_a = 0; log_b.delete();
    pressed[9] = 1'b1;
    cyc(90);
    chk("t1_ks9_before_3rd", ks_a[9], 0);
    cyc(60);
    chk("t1_ks9_after_3rd", ks_a[9], 1);
    cyc(90);
    pressed[9] = 1'b0;
    cyc(240);
    pop_a("t1_ev0", 9, 0);
    pop_a("t1_ev1", 9, 1);
    chk("t1_a_empty", val_a, 0);
    chk("t1_b_count", log_b.size(), 1);
    if (log_b.size() > 0) chk("t1_b_code", log_b[0], 9);

    // Bounce: two frames closed, one open -> nothing
    log_b.delete();
    pressed[9] = 1'b1;
    cyc(96);
    pressed[9] = 1'b0;
    cyc(200);
    chk("t2_ks9", ks_a[9], 0);
    chk("t2_no_ev_a", val_a, 0);
    chk("t2_no_ev_b", log_b.size(), 0);

    // Two keys on the same row in the same frame
    rdy_a = 1; log_a.delete();
    pressed[4] = 1'b1; pressed[7] = 1'b1;
    cyc(200);
    chk("t3_count", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      chk("t3_first", log_a[0], 4);
      chk("t3_second", log_a[1], 7);
    end
    pressed = '0;
    cyc(200);
    rdy_a = 0;

    // Overflow on a depth-4 FIFO, then clear
    do_reset();
    align();
    pressed = 16'h002F;  // keys 0,1,2,3,5
    cyc(124);
    chk("t4_overflow_set", ovf_a, 1);
    chk("t4_full_valid", val_a, 1);
    chk("t4_head", code_a, 0);
    chk("t4_b_no_overflow", ovf_b, 0);
    clr_a = 1;
    cyc(1);
    clr_a = 0;
    chk("t4_overflow_clr", ovf_a, 0);

    // Pop coinciding with the fifth write: write accepted, no overflow
    do_reset();
    align();
    pressed = 16'h002F;
    cyc(117);
    rdy_a = 1;
    cyc(1);
    rdy_a = 0;
    cyc(5);
    chk("t4b_no_overflow", ovf_a, 0);
    pop_a("t4b_ev1", 1, 0);
    pop_a("t4b_ev2", 2, 0);
    pop_a("t4b_ev3", 3, 0);
    pop_a("t4b_ev5", 5, 0);
    chk("t4b_empty", val_a, 0);

    // Press then release key 0: A reports both, B only the press
    do_reset();
    rdy_a = 1; log_a.delete(); log_b.delete();
    pressed[0] = 1'b1;
    cyc(200);
    pressed[0] = 1'b0;
    cyc(200);
    chk("t5_a_count", log_a.size(), 2);
    if (log_a.size() >= 2) begin
      chk("t5_a_press", log_a[0], 0);
      chk("t5_a_release", log_a[1], 16);
    end
    chk("t5_b_count", log_b.size(), 1);
    if (log_b.size() >= 1) chk("t5_b_press", log_b[0], 0);
    rdy_a = 0;

    // Reset mid-COMMIT with two events queued
    do_reset();
    align();
    pressed[0] = 1'b1; pressed[1] = 1'b1;
    cyc(110);
    chk("t6_queued_valid", val_a, 1);
    chk("t6_queued_head", code_a, 0);
    cyc(8);
    chk("t6_in_commit", row_a, 4'hF);
    RST = 1'b1;
    #1;
    chk("t6_rst_valid", val_a, 0);
    chk("t6_rst_key_state", ks_a, 0);
    chk("t6_rst_row", row_a, 4'hF);
    pressed = '0;
    cyc(2);
    RST = 1'b0;
    cyc(1);
    chk("t6_restart_row0", row_a, 4'hE);
    cyc(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (tests=%0d)", tests);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
